// File: rtl/sha256_round_ctrl.sv
// SHA-256 round sequencer: accepts 512-bit blocks, expands the message schedule in a 16-word window
// and drives the hash core's init/load/round/update controls. Build macro SHA256_CTRL_ABORT_EN adds 'abort'.
module sha256_round_ctrl #(
  parameter int ROUNDS = 64,
  parameter int BLK_W  = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [BLK_W-1:0] blk_data,
  input  logic             blk_last,
`ifdef SHA256_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             core_init,
  output logic             core_load,
  output logic             core_round_en,
  output logic [5:0]       core_round,
  output logic [31:0]      core_wt,
  output logic             core_update,
  input  logic [255:0]     core_digest,
  output logic             digest_valid,
  input  logic             digest_ready,
  output logic [255:0]     digest,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, START, ROUND, UPDATE, CAPTURE, DONE} state_t;

  localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

  state_t      state;
  logic [31:0] w [16];
  logic [31:0] w_next;
  logic        last_q;
  logic        msg_first;
  logic [5:0]  rnd;
  logic        update_q;
  logic        abort_req;

`ifdef SHA256_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // w[i] holds W[t+i] while round t is in progress
  always_comb begin
    w_next = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0];
  end

  // An abort during UPDATE must suppress the H accumulation in that same cycle
  assign core_update = update_q & ~abort_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      blk_ready     <= 1'b1;
      msg_first     <= 1'b1;
      last_q        <= 1'b0;
      rnd           <= '0;
      core_init     <= 1'b0;
      core_load     <= 1'b0;
      core_round_en <= 1'b0;
      core_round    <= '0;
      core_wt       <= '0;
      update_q      <= 1'b0;
      digest_valid  <= 1'b0;
      digest        <= '0;
      busy          <= 1'b0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      core_init <= 1'b0;
      core_load <= 1'b0;
      update_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (abort_req) begin
            msg_first <= 1'b1;
          end else if (blk_valid && blk_ready) begin
            for (int i = 0; i < 16; i++) w[i] <= blk_data[BLK_W-1-32*i -: 32];
            last_q    <= blk_last;
            core_init <= msg_first;
            core_load <= ~msg_first;
            blk_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (abort_req) begin
            msg_first <= 1'b1;
            blk_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            msg_first     <= 1'b0;
            rnd           <= '0;
            core_round_en <= 1'b1;
            core_round    <= '0;
            core_wt       <= w[0];
            state         <= ROUND;
          end
        end
        ROUND: begin
          if (abort_req) begin
            msg_first     <= 1'b1;
            core_round_en <= 1'b0;
            core_round    <= '0;
            core_wt       <= '0;
            blk_ready     <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end else begin
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= w_next;
            if (rnd == LAST_RND) begin
              core_round_en <= 1'b0;
              core_round    <= '0;
              core_wt       <= '0;
              update_q      <= 1'b1;
              state         <= UPDATE;
            end else begin
              rnd        <= rnd + 6'd1;
              core_round <= rnd + 6'd1;
              core_wt    <= w[1];
            end
          end
        end
        UPDATE: begin
          if (abort_req) begin
            msg_first <= 1'b1;
            blk_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (last_q) begin
            state <= CAPTURE;
          end else begin
            blk_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        CAPTURE: begin
          if (abort_req) begin
            msg_first <= 1'b1;
            blk_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            digest       <= core_digest;
            digest_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (abort_req || digest_ready) begin
            digest_valid <= 1'b0;
            msg_first    <= 1'b1;
            blk_ready    <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          blk_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: a behavioural SHA-256 core closes the loop, known vectors plus random
// multi-block messages are checked against a whole-array schedule/compression reference.
module tb_sha256_round_ctrl;

  localparam int ROUNDS = 64;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;
  logic         core_init, core_load, core_round_en, core_update;
  logic [5:0]   core_round;
  logic [31:0]  core_wt;
  logic [255:0] core_digest;
  logic         digest_valid;
  logic         digest_ready;
  logic [255:0] digest;
  logic         busy;
`ifdef SHA256_CTRL_ABORT_EN
  logic         abort;
`endif

  sha256_round_ctrl #(.ROUNDS(ROUNDS), .BLK_W(512)) dut (
    .clk(clk), .rst(rst),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
`ifdef SHA256_CTRL_ABORT_EN
    .abort(abort),
`endif
    .core_init(core_init), .core_load(core_load), .core_round_en(core_round_en),
    .core_round(core_round), .core_wt(core_wt), .core_update(core_update),
    .core_digest(core_digest), .digest_valid(digest_valid), .digest_ready(digest_ready),
    .digest(digest), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] doRound(input logic [255:0] s, input logic [31:0] k, input logic [31:0] wt);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + wt;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] addWords(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  // Full 64-entry schedule, packed so that W[t] sits at [32*t +: 32]
  function automatic logic [2047:0] refSchedule(input logic [511:0] blk);
    logic [31:0]   wv [64];
    logic [2047:0] r;
    for (int t = 0; t < 16; t++) wv[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      wv[t] = (rotr(wv[t-2], 17) ^ rotr(wv[t-2], 19) ^ (wv[t-2] >> 10)) + wv[t-7]
            + (rotr(wv[t-15], 7) ^ rotr(wv[t-15], 18) ^ (wv[t-15] >> 3)) + wv[t-16];
    for (int t = 0; t < 64; t++) r[32*t +: 32] = wv[t];
    return r;
  endfunction

  function automatic logic [255:0] refCompress(input logic [255:0] hin, input logic [511:0] blk);
    logic [2047:0] s;
    logic [255:0]  v;
    s = refSchedule(blk);
    v = hin;
    for (int t = 0; t < 64; t++) v = doRound(v, K[t], s[32*t +: 32]);
    return addWords(hin, v);
  endfunction

  // Behavioural hash core driven by the controller
  logic [255:0] coreH = '0;
  logic [255:0] coreV = '0;
  always @(posedge clk) begin
    if (core_init) begin
      coreH <= IV;
      coreV <= IV;
    end else if (core_load) begin
      coreV <= coreH;
    end else if (core_round_en) begin
      coreV <= doRound(coreV, K[core_round], core_wt);
    end else if (core_update) begin
      coreH <= addWords(coreH, coreV);
    end
  end
  assign core_digest = coreH;

  int          initCnt = 0, loadCnt = 0, updCnt = 0, onehotBad = 0, obsTotal = 0;
  logic [31:0] obsW [64];
  always @(negedge clk) begin
    if (!rst) begin
      if (core_init) initCnt++;
      if (core_load) loadCnt++;
      if (core_update) updCnt++;
      if ($countones({core_init, core_load, core_round_en, core_update}) > 1) onehotBad++;
      if (core_round_en) begin
        obsW[core_round] = core_wt;
        obsTotal++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  bit hsOk;

  task automatic applyStimulus(input logic [511:0] blk, input logic last, input int idle);
    hsOk = 1'b0;
    repeat (idle) @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (blk_ready) begin
        hsOk = 1'b1;
        break;
      end
    end
    if (!hsOk) begin
      checkOutput("hs_timeout", 0, 1);
      return;
    end
    blk_valid = 1'b1;
    blk_data  = blk;
    blk_last  = last;
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    for (int k = 0; k < 16; k++) blk_data[32*k +: 32] = $urandom();
    blk_last = 1'($urandom_range(0, 1));
  endtask

  task automatic runBlock(input logic [511:0] blk, input logic last, input logic first, input int idle);
    int i0, l0, u0, o0, h0, updEdge, dvEdge;
    logic [2047:0] s;
    i0 = initCnt; l0 = loadCnt; u0 = updCnt; o0 = obsTotal; h0 = onehotBad;
    s = refSchedule(blk);
    applyStimulus(blk, last, idle);
    if (!hsOk) return;
    updEdge = 0;
    dvEdge  = 0;
    for (int e = 1; e <= 90; e++) begin
      @(posedge clk);
      #1;
      if (core_update && updEdge == 0) updEdge = e;
      if (digest_valid && dvEdge == 0) dvEdge = e;
      if (last ? (dvEdge != 0) : (updEdge != 0 && blk_ready)) break;
    end
    // Update pulse spans the (1+ROUNDS+1)th cycle; digest_valid rises 1+ROUNDS+2 edges after handshake
    checkOutput("upd_lat", updEdge, ROUNDS + 1);
    if (last) begin
      checkOutput("dv_lat", dvEdge, ROUNDS + 3);
      checkOutput("rdy_done", blk_ready, 0);
    end else begin
      checkOutput("no_dv", dvEdge, 0);
    end
    checkOutput("init_load", {initCnt - i0, loadCnt - l0}, {32'(first ? 1 : 0), 32'(first ? 0 : 1)});
    checkOutput("upd_cnt", updCnt - u0, 1);
    checkOutput("round_cnt", obsTotal - o0, ROUNDS);
    checkOutput("onehot", onehotBad - h0, 0);
    for (int t = 0; t < ROUNDS; t++) checkOutput($sformatf("wt%0d", t), obsW[t], s[32*t +: 32]);
  endtask

  task automatic finishMessage(input logic [255:0] exp, input int hold);
    logic [255:0] d0;
    int unstable;
    d0 = digest;
    unstable = 0;
    checkOutput("digest", digest, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (digest !== d0 || !digest_valid || blk_ready) unstable++;
    end
    if (hold > 0) checkOutput("hold", unstable, 0);
    @(negedge clk);
    digest_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("dv_clr", digest_valid, 0);
    checkOutput("rdy_back", blk_ready, 1);
    @(negedge clk);
    digest_ready = 1'b0;
  endtask

  logic [511:0] abcBlk, emptyBlk, twoB1, twoB2, blk;
  logic [255:0] abcDig, emptyDig, twoDig, hExp;
  bit           found;
  int           nb, u0;

  initial begin
    abcBlk   = {32'h61626380, 448'h0, 32'h00000018};
    emptyBlk = {32'h80000000, 480'h0};
    twoB1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
                32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    twoB2    = {480'h0, 32'h000001c0};
    abcDig   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    emptyDig = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    twoDig   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    rst = 1'b1; blk_valid = 1'b0; blk_data = '0; blk_last = 1'b0; digest_ready = 1'b0;
`ifdef SHA256_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("rst_rdy", blk_ready, 1);
    checkOutput("rst_ctl", {busy, core_init, core_load, core_round_en, core_update, digest_valid, core_round, core_wt}, 0);
    checkOutput("rst_dig", digest, 0);
    rst = 1'b0;

    $display("[TB] abc single block");
    runBlock(abcBlk, 1'b1, 1'b1, 0);
    checkOutput("abc_w0", obsW[0], 32'h61626380);
    checkOutput("abc_w15", obsW[15], 32'h00000018);
    checkOutput("abc_w16", obsW[16], 32'h61626380);
    finishMessage(abcDig, 2);

    $display("[TB] empty message");
    runBlock(emptyBlk, 1'b1, 1'b1, 1);
    finishMessage(emptyDig, 0);

    $display("[TB] two-block message, digest held 20 cycles");
    runBlock(twoB1, 1'b0, 1'b1, 0);
    runBlock(twoB2, 1'b1, 1'b0, 0);
    finishMessage(twoDig, 20);
    runBlock(abcBlk, 1'b1, 1'b1, 0);
    finishMessage(abcDig, 1);

    $display("[TB] random multi-block messages");
    for (int m = 0; m < 5; m++) begin
      nb   = $urandom_range(1, 3);
      hExp = IV;
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < 16; k++) blk[32*k +: 32] = $urandom();
        hExp = refCompress(hExp, blk);
        runBlock(blk, 1'(b == nb - 1), 1'(b == 0), $urandom_range(0, 3));
      end
      finishMessage(hExp, $urandom_range(0, 5));
    end

    $display("[TB] reset at round 30");
    applyStimulus(abcBlk, 1'b1, 0);
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (core_round_en && core_round == 6'd30) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("rst_hit", found, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_rdy", blk_ready, 1);
    checkOutput("arst_ctl", {busy, core_init, core_load, core_round_en, core_update, digest_valid, core_round, core_wt}, 0);
    checkOutput("arst_dig", digest, 0);
    @(negedge clk);
    rst = 1'b0;
    runBlock(abcBlk, 1'b1, 1'b1, 0);
    finishMessage(abcDig, 0);

`ifdef SHA256_CTRL_ABORT_EN
    $display("[TB] abort at round 40");
    u0 = updCnt;
    applyStimulus(twoB1, 1'b0, 0);
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (core_round_en && core_round == 6'd40) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("abort_hit", found, 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_idle", {blk_ready, busy, core_round_en}, 3'b100);
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_noupd", updCnt - u0, 0);
    runBlock(abcBlk, 1'b1, 1'b1, 0);
    finishMessage(abcDig, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
Sequencing controller for the SHA-256 round datapath (hash core). It accepts 512-bit message blocks over a valid/ready handshake and expands each into the 64-word schedule Wt with an internal 16-word sliding window. It drives the core's init, round-enable, chain-update and round-index controls, then returns the 256-bit digest over a valid/ready handshake. It sits between the padding/block front end and the hash core, and handles multi-block messages by chaining H between blocks.

Parameters:
ROUNDS, 64, rounds per block; 64 for compliance, smaller values for debug only, legal range 17..64.
BLK_W, 512, message block width; fixed at 16 x 32-bit words.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
blk_valid  in  1  block available.
blk_ready  out  1  controller can accept a block.
blk_data  in  512  block, big-endian: word0 = [511:480].
blk_last  in  1  qualifies blk_data; final block of the message.
core_init  out  1  1-cycle pulse: core loads working vars and H from the IV.
core_load  out  1  1-cycle pulse: core loads working vars from the current H (chained block).
core_round_en  out  1  core performs one round this cycle.
core_round  out  6  round index t, used for the Kt lookup.
core_wt  out  32  schedule word Wt for round t.
core_update  out  1  1-cycle pulse: core performs H[i] += working var i.
core_digest  in  256  core H0..H7 concatenation.
digest_valid  out  1  digest available.
digest_ready  in  1  consumer accepts the digest.
digest  out  256  registered final hash.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, blk_ready=1, msg_first=1, and every other output 0 (including digest and core_wt). The schedule window is cleared.
- States: IDLE, START, ROUND, UPDATE, CAPTURE, DONE.
- IDLE
  - blk_ready=1.
  - On blk_valid&&blk_ready: latch W[0..15] and last. Go to START.
- START (1 cycle)
  - Pulse core_init if msg_first=1, otherwise pulse core_load.
  - Clear msg_first. Set rnd=0. Go to ROUND.
- ROUND
  - core_round_en=1, core_round=rnd, core_wt=W[0].
  - Each cycle: shift the window down one word and append W[15] = sigma1(W[14]) + W[9] + sigma0(W[1]) + W[0], all mod 2^32.
  - sigma0 = ROTR7^ROTR18^SHR3; sigma1 = ROTR17^ROTR19^SHR10.
  - Words t=0..15 are the raw block words; t>=16 are expanded words.
  - When rnd=ROUNDS-1, go to UPDATE.
- UPDATE (1 cycle)
  - Pulse core_update.
  - If last, go to CAPTURE. Otherwise set blk_ready=1 and return to IDLE, with msg_first staying 0.
- CAPTURE (1 cycle): register core_digest into digest, set digest_valid=1, go to DONE.
- DONE
  - Hold digest and digest_valid stable until digest_ready.
  - On digest_ready: clear digest_valid, set msg_first=1, go to IDLE.
  - blk_ready=0 throughout DONE, so a new message cannot start before the digest is taken.
- Latency
  - Block handshake to core_update pulse: 1 + ROUNDS + 1 = 66 cycles.
  - Handshake of the last block to digest_valid: 67 cycles.
- Per-block throughput: 67 cycles including the IDLE accept cycle.
- blk_ready is 0 in START, ROUND, UPDATE, CAPTURE and DONE. blk_data and blk_last are ignored when not accepted.
- Only one of core_init, core_load, core_round_en, core_update is high in any cycle.
- rnd is 6 bits and never wraps past ROUNDS-1.
- Reset mid-operation returns to IDLE immediately and drops any partial message. The core is re-initialised by the next core_init.
- digest_ready while digest_valid=0 is ignored.

Optional Feature:
SHA256_CTRL_ABORT_EN
- Enabled: adds input abort (1 bit).
  - abort=1 in START, ROUND or UPDATE forces IDLE on the next edge, with no core_update and msg_first=1.
  - abort in CAPTURE or DONE clears digest_valid and returns to IDLE.
  - abort in IDLE sets msg_first=1.
  - If abort and blk_valid are both high in IDLE, abort wins and no block is accepted.
- Disabled: no abort port, and the FSM is exactly as above.

Test Plan:
- "abc", one block (blk_data=61626380 00..00 00000018, blk_last=1)
  - core_init once; core_wt t0=61626380, t15=00000018, t16=61626380.
  - digest = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 67 cycles after the handshake.
- Empty message (80000000 00..00, last=1) -> digest = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- Two-block "abcdbcdecdefdefg...nopq" (448 bits)
  - First block: core_init. Second block: core_load.
  - No digest_valid after block 1.
  - digest = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- digest_ready held 0 for 20 cycles
  - digest stable and blk_ready=0 throughout.
  - One cycle after digest_ready=1: digest_valid=0, blk_ready=1.
  - A following "abc" gives the correct digest, proving msg_first reset.
- rst asserted at round 30
  - All outputs 0 and blk_ready=1 asynchronously.
  - A next "abc" block yields the correct digest via core_init.
- SHA256_CTRL_ABORT_EN defined, abort at round 40 of block 1 of the two-block message
  - No core_update; returns to IDLE.
  - Resending "abc" gives ba7816bf...f20015ad.
